// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified byte memory between fetch and the MEM stage.
// Optional perf counters are built only when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,

    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [2:0]    d_funct3_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,

    output logic          stall_if_o,
    output logic          stall_d_o,
    output logic          last_owner_o,

    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic [2:0]    mem_choose_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,

    output logic [15:0]   perf_conflicts_o,
    output logic [15:0]   perf_starve_ovr_o
);

    // Keep at least one bit so STARVE_MAX == 0 still elaborates.
    localparam int unsigned CW = (STARVE_MAX == 0) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);
    localparam logic [2:0] FunctWord = 3'b010;

    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          last_owner_q, last_owner_d;
    logic          ovr;

    always_comb begin
        ovr      = (STARVE_MAX != 0) && (starve_cnt_q == StarveMax) && if_req_i;
        d_gnt_o  = d_req_i & ~ovr;
        if_gnt_o = if_req_i & (~d_req_i | ovr);
    end

    assign stall_if_o = if_req_i & ~if_gnt_o;
    assign stall_d_o  = d_req_i & ~d_gnt_o;

    always_comb begin
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_choose_o = '0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        if (d_gnt_o) begin
            mem_read_o   = ~d_we_i;
            mem_write_o  = d_we_i;
            mem_choose_o = d_funct3_i;
            mem_addr_o   = d_addr_i;
            mem_wdata_o  = d_wdata_i;
        end else if (if_gnt_o) begin
            mem_read_o   = 1'b1;
            mem_choose_o = FunctWord;
            mem_addr_o   = if_addr_i;
        end
    end

    always_comb begin
        if_rvalid_d  = if_gnt_o;
        d_rvalid_d   = d_gnt_o & ~d_we_i;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        starve_cnt_d = '0;
        last_owner_d = last_owner_q;
        if (if_gnt_o) begin
            if_rdata_d = mem_rdata_i;
        end
        if (d_rvalid_d) begin
            d_rdata_d = mem_rdata_i;
        end
        if (if_req_i && !if_gnt_o) begin
            starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
        if (d_gnt_o) begin
            last_owner_d = 1'b1;
        end else if (if_gnt_o) begin
            last_owner_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            starve_cnt_q <= '0;
            last_owner_q <= 1'b0;
        end else begin
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            starve_cnt_q <= starve_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign if_rvalid_o  = if_rvalid_q;
    assign d_rvalid_o   = d_rvalid_q;
    assign if_rdata_o   = if_rdata_q;
    assign d_rdata_o    = d_rdata_q;
    assign last_owner_o = last_owner_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_conflicts_q, perf_conflicts_d;
    logic [15:0] perf_starve_ovr_q, perf_starve_ovr_d;

    always_comb begin
        perf_conflicts_d  = perf_conflicts_q;
        perf_starve_ovr_d = perf_starve_ovr_q;
        if (if_req_i && d_req_i && perf_conflicts_q != 16'hFFFF) begin
            perf_conflicts_d = perf_conflicts_q + 16'd1;
        end
        if (ovr && d_req_i && perf_starve_ovr_q != 16'hFFFF) begin
            perf_starve_ovr_d = perf_starve_ovr_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflicts_q  <= '0;
            perf_starve_ovr_q <= '0;
        end else begin
            perf_conflicts_q  <= perf_conflicts_d;
            perf_starve_ovr_q <= perf_starve_ovr_d;
        end
    end

    assign perf_conflicts_o  = perf_conflicts_q;
    assign perf_starve_ovr_o = perf_starve_ovr_q;
`else
    assign perf_conflicts_o  = '0;
    assign perf_starve_ovr_o = '0;
`endif

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(if_gnt_o && d_gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(if_rvalid_o && d_rvalid_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a big-endian byte memory
// and a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned SM = 3;
`ifdef ARB_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [2:0]  d_funct3;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        stall_if, stall_d, last_owner;
    logic        mem_read, mem_write;
    logic [2:0]  mem_choose;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] perf_conflicts, perf_starve_ovr;

    mem_port_arbiter #(.STARVE_MAX(SM), .AW(8), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_funct3_i(d_funct3), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .stall_if_o(stall_if), .stall_d_o(stall_d), .last_owner_o(last_owner),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_choose_o(mem_choose),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .perf_conflicts_o(perf_conflicts), .perf_starve_ovr_o(perf_starve_ovr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            4: return 8'h02;
            5: return 8'h10;
            6: return 8'h81;
            7: return 8'h33;
            248, 249, 250: return 8'h00;
            251: return 8'h09;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // Physical memory: combinational big-endian read, write at the clock edge.
    logic [7:0] mem [256];
    logic       init_done = 1'b0;
    logic [7:0] rb0, rb1, rb2, rb3;

    always_comb begin
        rb0 = mem[mem_addr];
        rb1 = mem[mem_addr + 8'd1];
        rb2 = mem[mem_addr + 8'd2];
        rb3 = mem[mem_addr + 8'd3];
        case (mem_choose)
            3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
            3'b001:  mem_rdata = {{16{rb0[7]}}, rb0, rb1};
            3'b100:  mem_rdata = {24'd0, rb0};
            3'b101:  mem_rdata = {16'd0, rb0, rb1};
            default: mem_rdata = {rb0, rb1, rb2, rb3};
        endcase
    end

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            init_done <= 1'b1;
        end else if (mem_write) begin
            case (mem_choose)
                3'b000: mem[mem_addr] <= mem_wdata[7:0];
                3'b001: begin
                    mem[mem_addr]        <= mem_wdata[15:8];
                    mem[mem_addr + 8'd1] <= mem_wdata[7:0];
                end
                default: begin
                    mem[mem_addr]        <= mem_wdata[31:24];
                    mem[mem_addr + 8'd1] <= mem_wdata[23:16];
                    mem[mem_addr + 8'd2] <= mem_wdata[15:8];
                    mem[mem_addr + 8'd3] <= mem_wdata[7:0];
                end
            endcase
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [256];
    int          m_denied;
    logic        m_irv, m_drv, m_owner, obs_dgnt;
    logic [31:0] m_ird, m_drd;
    int          m_pc, m_ps;
    int          n_vec = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] f3);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = ref_mem[(int'(a) + k) % 256];
        case (f3)
            3'b000:  return {{24{b[0][7]}}, b[0]};
            3'b001:  return {{16{b[0][7]}}, b[0], b[1]};
            3'b100:  return {24'd0, b[0]};
            3'b101:  return {16'd0, b[0], b[1]};
            default: return {b[0], b[1], b[2], b[3]};
        endcase
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [2:0] f3, input logic [31:0] w);
        int n;
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 256] = 8'(w >> (8 * (n - 1 - k)));
    endtask

    task automatic model_reset();
        m_denied = 0; m_irv = 0; m_drv = 0; m_ird = 0; m_drd = 0;
        m_owner = 0; m_pc = 0; m_ps = 0;
    endtask

    task automatic check_regs();
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_irv});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_drv});
        chk("if_rdata", if_rdata, m_ird);
        chk("d_rdata", d_rdata, m_drd);
        chk("last_owner", {31'd0, last_owner}, {31'd0, m_owner});
        chk("perf_conflicts", {16'd0, perf_conflicts}, PerfEn ? m_pc : 0);
        chk("perf_starve_ovr", {16'd0, perf_starve_ovr}, PerfEn ? m_ps : 0);
    endtask

    task automatic step(input logic ireq, input logic [7:0] iaddr, input logic dreq,
                        input logic dwe, input logic [2:0] df3, input logic [7:0] daddr,
                        input logic [31:0] dwd);
        logic ovr, dg, ig;
        if_req = ireq; if_addr = iaddr; d_req = dreq; d_we = dwe;
        d_funct3 = df3; d_addr = daddr; d_wdata = dwd;
        #2;
        // Fetch has waited SM cycles in a row: it takes this cycle.
        ovr = (SM != 0) && (m_denied == SM) && ireq;
        dg  = dreq && !ovr;
        ig  = ireq && !dg;
        obs_dgnt = d_gnt;
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, dg});
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, ig});
        chk("stall_if", {31'd0, stall_if}, {31'd0, ireq && !ig});
        chk("stall_d", {31'd0, stall_d}, {31'd0, dreq && !dg});
        chk("mem_read", {31'd0, mem_read}, {31'd0, dg ? !dwe : ig});
        chk("mem_write", {31'd0, mem_write}, {31'd0, dg && dwe});
        chk("mem_choose", {29'd0, mem_choose}, {29'd0, dg ? df3 : ig ? 3'b010 : 3'b000});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, dg ? daddr : ig ? iaddr : 8'd0});
        chk("mem_wdata", mem_wdata, dg ? dwd : 32'd0);
        m_irv = ig;
        m_drv = dg && !dwe;
        if (ig) m_ird = ref_load(iaddr, 3'b010);
        if (m_drv) m_drd = ref_load(daddr, df3);
        if (dg && dwe) ref_store(daddr, df3, dwd);
        m_denied = (ireq && !ig) ? ((m_denied >= int'(SM)) ? m_denied : m_denied + 1) : 0;
        if (dg) m_owner = 1'b1;
        else if (ig) m_owner = 1'b0;
        if (ireq && dreq && m_pc < 65535) m_pc++;
        if (ovr && dreq && m_ps < 65535) m_ps++;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        st_f3[0] = 3'b000; st_f3[1] = 3'b001; st_f3[2] = 3'b010;
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 8'h00, 0, 0, 3'b000, 8'h00, 32'h0);
        step(1, 8'h04, 0, 0, 3'b000, 8'h00, 32'h0);
        chk("tp_fetch_rdata", if_rdata, 32'h02108133);
        step(1, 8'h08, 1, 0, 3'b010, 8'hF8, 32'h0);
        chk("tp_load_rdata", d_rdata, 32'd9);
        step(0, 8'h00, 1, 1, 3'b010, 8'h40, 32'hDEADBEEF);
        chk("tp_sw_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        step(0, 8'h00, 1, 0, 3'b000, 8'h40, 32'h0);
        chk("tp_lb_rdata", d_rdata, 32'hFFFFFFDE);

        step(0, 8'h00, 0, 0, 3'b000, 8'h00, 32'h0);
        for (int k = 0; k < 8; k++) begin
            step(1, 8'(k * 4), 1, 0, 3'b010, 8'(8'h80 + k), 32'h0);
            chk("tp_starve_pattern", {31'd0, obs_dgnt}, {31'd0, (k % 4) != 3});
        end

        // Build up starvation with a load in flight, then reset asynchronously.
        step(0, 8'h00, 0, 0, 3'b000, 8'h00, 32'h0);
        step(1, 8'h10, 1, 0, 3'b010, 8'h20, 32'h0);
        step(1, 8'h10, 1, 0, 3'b010, 8'h24, 32'h0);
        step(1, 8'h10, 1, 0, 3'b010, 8'hF8, 32'h0);
        if_req = 0; d_req = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1, 8'(k * 4), 1, 0, 3'b010, 8'(k), 32'h0);
            if (k == 0) chk("tp_rst_plain_prio", {31'd0, obs_dgnt}, 32'd1);
        end
        chk("tp_perf_conflicts", {16'd0, perf_conflicts}, PerfEn ? 32'd10 : 32'd0);
        chk("tp_perf_starve_ovr", {16'd0, perf_starve_ovr}, PerfEn ? 32'd2 : 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic ireq, dreq, dwe;
            ireq = ($urandom_range(0, 3) != 0);
            dreq = ($urandom_range(0, 4) != 0);
            dwe  = ($urandom_range(0, 2) == 0);
            step(ireq, 8'($urandom), dreq, dwe,
                 dwe ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)],
                 8'($urandom), $urandom);
        end
        step(0, 8'h00, 0, 0, 3'b000, 8'h00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
